// File: rtl/rom_ram_pkg.sv
// Shared definitions for the ROM-to-RAM copy sequencer.
//   DATA_W    : width of the ROM/RAM data words
//   S_*       : FSM state encodings
//   scr()     : fixed bit-scramble applied to every copied word
package rom_ram_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CP_RD  = 3'd1;
    localparam logic [2:0] S_CP_WR  = 3'd2;
    localparam logic [2:0] S_VF_RD  = 3'd3;
    localparam logic [2:0] S_VF_CMP = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Bit order of the result, MSB first: d0 d7 d1 d6 d2 d5 d3 d4.
    function automatic logic [DATA_W-1:0] scr(input logic [DATA_W-1:0] d);
        return {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]};
    endfunction

endpackage

// File: rtl/scramble8.sv
// Combinational wrapper around scr(); one instance serves both the copy
// and the verify paths since they never read the ROM in the same cycle.
//   d_i : raw ROM word
//   q_o : scrambled word
module scramble8
    import rom_ram_pkg::*;
(
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    assign q_o = scr(d_i);

endmodule

// File: rtl/rom_ram_copy_ctrl.sv
// Copies ROM[START_ADDR..END_ADDR] into RAM through one shared address bus,
// scrambling each word, then optionally reads the RAM back and counts
// mismatches against the freshly scrambled ROM data.
//   clk_i, reset_i         : clock, asynchronous active-high reset
//   start_i                : one-cycle request, honoured only when idle
//   busy_o, done_o         : status (done is a one-cycle pulse)
//   err_cnt_o, err_addr_o  : saturating mismatch count, first failing address
//   addr_o                 : registered shared ROM/RAM address
//   rom_cs_n_o, rom_oe_o   : ROM selects; rom_data_i is its read data
//   ram_cs_n_o, ram_oe_o,
//   ram_ws_o, ram_data_io  : RAM selects, write strobe, bidirectional data
module rom_ram_copy_ctrl
    import rom_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 5'h04,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 5'h1E,
    parameter bit                    VERIFY_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            err_cnt_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  rom_cs_n_o,
    output logic                  rom_oe_o,
    input  logic [DATA_W-1:0]     rom_data_i,
    output logic                  ram_cs_n_o,
    output logic                  ram_oe_o,
    output logic                  ram_ws_o,
    inout  wire  [DATA_W-1:0]     ram_data_io
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;   // write data in copy, expected data in verify
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0]     rom_scr;
    logic                  last;

    scramble8 u_scr (
        .d_i (rom_data_i),
        .q_o (rom_scr)
    );

    // END_ADDR is tested before addr + 1 is used, so the top address is
    // legal and the counter never wraps.
    assign last = (addr_q == END_ADDR);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_CP_RD;
                    addr_d     = START_ADDR;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                end
            end
            S_CP_RD: begin
                data_d  = rom_scr;
                state_d = S_CP_WR;
            end
            S_CP_WR: begin
                if (!last) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_CP_RD;
                end else if (VERIFY_EN) begin
                    addr_d  = START_ADDR;
                    state_d = S_VF_RD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_VF_RD: begin
                data_d  = rom_scr;
                state_d = S_VF_CMP;
            end
            S_VF_CMP: begin
                if (ram_data_io != data_q) begin
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    if (err_cnt_q == 8'h00) err_addr_d = addr_q;
                end
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_VF_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            addr_q     <= START_ADDR;
            data_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Strobes decode straight from the state register, so reset drops them
    // without waiting for a clock edge.
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign rom_oe_o   = (state_q == S_CP_RD) || (state_q == S_VF_RD);
    assign rom_cs_n_o = !rom_oe_o;
    assign ram_ws_o   = (state_q == S_CP_WR);
    assign ram_oe_o   = (state_q == S_VF_CMP);
    assign ram_cs_n_o = !(ram_ws_o || ram_oe_o);
    assign ram_data_io = ram_ws_o ? data_q : {DATA_W{1'bz}};

    assign addr_o     = addr_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_rom_ram_copy_ctrl.sv
// Three sequencers share one ROM image: u0 default window with verify,
// u1 a single word at the top address, u2 default window without verify.
module tb_rom_ram_copy_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] start;
    logic corrupt;
    logic [2:0] busy, done, rom_cs_n, rom_oe, ram_cs_n, ram_oe, ram_ws;
    logic [2:0][4:0] addr, err_addr;
    logic [2:0][7:0] err_cnt, rom_data;
    wire  [7:0] rd0, rd1, rd2;

    logic [7:0] rom [32];
    logic [7:0] ram [3][32];

    int cyc = 0, start_cyc = 0;
    int errors = 0, checks = 0;
    logic mon_clr, clr_ram;
    int done_n[3], done_at[3], wr_n[3];
    int viol, u2_rd, u1_zero, first_wr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_ram_copy_ctrl u0 (
        .clk_i(clk), .reset_i(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .err_cnt_o(err_cnt[0]), .err_addr_o(err_addr[0]), .addr_o(addr[0]),
        .rom_cs_n_o(rom_cs_n[0]), .rom_oe_o(rom_oe[0]), .rom_data_i(rom_data[0]),
        .ram_cs_n_o(ram_cs_n[0]), .ram_oe_o(ram_oe[0]), .ram_ws_o(ram_ws[0]), .ram_data_io(rd0));

    rom_ram_copy_ctrl #(.START_ADDR(5'h1F), .END_ADDR(5'h1F)) u1 (
        .clk_i(clk), .reset_i(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .err_cnt_o(err_cnt[1]), .err_addr_o(err_addr[1]), .addr_o(addr[1]),
        .rom_cs_n_o(rom_cs_n[1]), .rom_oe_o(rom_oe[1]), .rom_data_i(rom_data[1]),
        .ram_cs_n_o(ram_cs_n[1]), .ram_oe_o(ram_oe[1]), .ram_ws_o(ram_ws[1]), .ram_data_io(rd1));

    rom_ram_copy_ctrl #(.VERIFY_EN(1'b0)) u2 (
        .clk_i(clk), .reset_i(rst), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
        .err_cnt_o(err_cnt[2]), .err_addr_o(err_addr[2]), .addr_o(addr[2]),
        .rom_cs_n_o(rom_cs_n[2]), .rom_oe_o(rom_oe[2]), .rom_data_i(rom_data[2]),
        .ram_cs_n_o(ram_cs_n[2]), .ram_oe_o(ram_oe[2]), .ram_ws_o(ram_ws[2]), .ram_data_io(rd2));

    // ROM models: combinational read when selected and enabled.
    for (genvar k = 0; k < 3; k++) begin : g_rom
        assign rom_data[k] = (!rom_cs_n[k] && rom_oe[k]) ? rom[addr[k]] : 8'h00;
    end

    // RAM read drivers; 'corrupt' forces bit 0 of word 8 as seen by u0.
    assign rd0 = (!ram_cs_n[0] && ram_oe[0]) ?
                 (ram[0][addr[0]] ^ {7'b0, corrupt && (addr[0] == 5'h08)}) : 8'bz;
    assign rd1 = (!ram_cs_n[1] && ram_oe[1]) ? ram[1][addr[1]] : 8'bz;
    assign rd2 = (!ram_cs_n[2] && ram_oe[2]) ? ram[2][addr[2]] : 8'bz;

    // RAM writes and bus monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_clr) begin
            for (int k = 0; k < 3; k++) begin
                done_n[k] <= 0; done_at[k] <= -1; wr_n[k] <= 0;
                if (clr_ram) for (int a = 0; a < 32; a++) ram[k][a] <= 8'h00;
            end
            viol <= 0; u2_rd <= 0; u1_zero <= 0; first_wr <= -1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin done_n[k] <= done_n[k] + 1; done_at[k] <= cyc - start_cyc; end
                if (!ram_cs_n[k] && ram_ws[k]) wr_n[k] <= wr_n[k] + 1;
                if ((ram_ws[k] && ram_oe[k]) || (rom_oe[k] && (ram_oe[k] || ram_ws[k])))
                    viol <= viol + 1;
            end
            if (!ram_cs_n[0] && ram_ws[0]) ram[0][addr[0]] <= rd0;
            if (!ram_cs_n[1] && ram_ws[1]) ram[1][addr[1]] <= rd1;
            if (!ram_cs_n[2] && ram_ws[2]) ram[2][addr[2]] <= rd2;
            if (first_wr < 0 && !ram_cs_n[0] && ram_ws[0]) first_wr <= int'(addr[0]);
            if (ram_oe[2]) u2_rd <= u2_rd + 1;
            if (addr[1] == 5'h00) u1_zero <= u1_zero + 1;
        end
    end

    // Reference scramble: output bit 7-i takes input bit src[i].
    function automatic logic [7:0] ref_scr(input logic [7:0] d);
        int src [8] = '{0, 7, 1, 6, 2, 5, 3, 4};
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = d[src[i]];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] m);
        start = m;
        start_cyc = cyc;
        @(negedge clk);
        start = 3'b000;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    // Expected image of a RAM copied from window [lo, hi].
    task automatic chk_image(input int k, input int lo, input int hi, input string name);
        int bad = 0;
        for (int a = 0; a < 32; a++) begin
            logic [7:0] e;
            e = (a >= lo && a <= hi) ? ref_scr(rom[a]) : 8'h00;
            if (ram[k][a] !== e) bad++;
        end
        chk(name, bad, 0);
    endtask

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tab [12];

    initial begin
        int n;
        tab = '{'{5'h04, 8'h01, 8'h80}, '{5'h05, 8'h80, 8'h40}, '{5'h06, 8'h02, 8'h20},
                '{5'h07, 8'h40, 8'h10}, '{5'h08, 8'h04, 8'h08}, '{5'h09, 8'h20, 8'h04},
                '{5'h0A, 8'h08, 8'h02}, '{5'h0B, 8'h10, 8'h01}, '{5'h0C, 8'hA5, 8'hCC},
                '{5'h0D, 8'h0F, 8'hAA}, '{5'h1D, 8'h00, 8'h00}, '{5'h1E, 8'hFF, 8'hFF}};
        rst = 1'b1; start = 3'b000; corrupt = 1'b0; mon_clr = 1'b1; clr_ram = 1'b1;
        for (int a = 0; a < 32; a++) rom[a] = 8'($urandom);
        for (int i = 0; i < 12; i++) rom[tab[i].a] = tab[i].d;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_addr", addr[0], 'h04);
        chk("rst_addr_u1", addr[1], 'h1F);
        chk("rst_err_cnt", err_cnt[0], 0);
        chk("rst_err_addr", err_addr[0], 0);
        chk("rst_selects", {rom_cs_n[0], ram_cs_n[0], rom_oe[0], ram_oe[0], ram_ws[0]}, 'b11000);
        rst = 1'b0; clr_ram = 1'b0; mon_clr = 1'b0;
        @(negedge clk);

        // Run 1: full copy + verify, with a second start while busy
        pulse_start(3'b111);
        chk("busy_after_start", busy[0], 1);
        repeat (18) @(negedge clk);
        start = 3'b101;
        @(negedge clk);
        start = 3'b000;
        repeat (120) @(negedge clk);
        chk("done_at_u0", done_at[0], 109);
        chk("done_at_u1", done_at[1], 5);
        chk("done_at_u2", done_at[2], 55);
        chk("done_cnt_u0", done_n[0], 1);
        chk("done_cnt_u1", done_n[1], 1);
        chk("done_cnt_u2", done_n[2], 1);
        for (int i = 0; i < 12; i++)
            chk($sformatf("tab_ram[%0h]", tab[i].a), ram[0][tab[i].a], tab[i].exp);
        chk_image(0, 4, 30, "image_u0");
        chk_image(1, 31, 31, "image_u1");
        chk_image(2, 4, 30, "image_u2");
        chk("writes_u0", wr_n[0], 27);
        chk("writes_u1", wr_n[1], 1);
        chk("err_cnt_u0", err_cnt[0], 0);
        chk("err_cnt_u1", err_cnt[1], 0);
        chk("u1_addr_zero", u1_zero, 0);
        chk("u2_ram_reads", u2_rd, 0);
        chk("busy_idle", busy, 0);
        chk("invariants_run1", viol, 0);

        // Run 2: word 8 reads back with bit 0 flipped
        clear_mon();
        corrupt = 1'b1;
        pulse_start(3'b001);
        repeat (125) @(negedge clk);
        chk("corrupt_done_at", done_at[0], 109);
        chk("corrupt_err_cnt", err_cnt[0], 1);
        chk("corrupt_err_addr", err_addr[0], 'h08);
        repeat (5) @(negedge clk);
        chk("err_cnt_hold", err_cnt[0], 1);
        corrupt = 1'b0;

        // Run 3: asynchronous reset during the write of word 0x0A
        clear_mon();
        pulse_start(3'b001);
        n = 0;
        while (!(ram_ws[0] && addr[0] == 5'h0A) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr_0A", n < 100, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy[0], 0);
        chk("arst_selects", {rom_cs_n[0], ram_cs_n[0], rom_oe[0], ram_oe[0], ram_ws[0]}, 'b11000);
        chk("arst_addr", addr[0], 'h04);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        pulse_start(3'b001);
        repeat (125) @(negedge clk);
        chk("restart_first_wr", first_wr, 'h04);
        chk("restart_done_at", done_at[0], 109);
        chk("restart_err_cnt", err_cnt[0], 0);
        chk_image(0, 4, 30, "image_restart");
        chk("invariants_run3", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
